// File: rtl/score_pkg.sv
// Shared score constants and converter state type; defaults match the scoreboard.
package score_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned DEF_DIGITS  = 2;
  localparam int unsigned DEF_BIN_W   = 7;
  localparam int unsigned DEF_MAX_VAL = 31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-nibble correction for reverse double-dabble: digits >= 8 lose 3 after each right shift.
module bcd_digit_adjust
  import score_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= 4'd8) adjusted = digit - 4'd3;
  end

endmodule

// File: rtl/bcd_to_score.sv
// Sequential BCD-to-binary converter with saturation to MAX_VAL.
// Optional invalid-digit check enabled by defining BCD_TO_SCORE_CHECK_EN.
module bcd_to_score
  import score_pkg::*;
#(
  parameter int unsigned DIGITS  = DEF_DIGITS,
  parameter int unsigned BIN_W   = DEF_BIN_W,
  parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          sat,
  output logic                          err
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX  = BIN_W'(MAX_VAL);

  state_t           state;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] bin;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_next;
  logic [BIN_W-1:0] bin_next;

  assign {bcd_shift, bin_next} = {bcd, bin} >> 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit   (bcd_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted(bcd_next[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_TO_SCORE_CHECK_EN
  logic bad_in;
  logic bad;

  always_comb begin
    bad_in = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad_in = 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin_out   <= '0;
      sat       <= 1'b0;
      cnt       <= '0;
      bcd       <= '0;
      bin       <= '0;
`ifdef BCD_TO_SCORE_CHECK_EN
      err       <= 1'b0;
      bad       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bcd      <= bcd_in;
            bin      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
`ifdef BCD_TO_SCORE_CHECK_EN
            bad      <= bad_in;
`endif
          end
        end
        SHIFT: begin
          bcd <= bcd_next;
          bin <= bin_next;
          cnt <= cnt + CNT_W'(1);
          // Outputs are taken from the final shift directly so the result lands on edge E0+BIN_W.
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef BCD_TO_SCORE_CHECK_EN
            err       <= bad;
            if (bad) begin
              bin_out <= '0;
              sat     <= 1'b0;
            end else
`endif
            if (bin_next > MAX) begin
              bin_out <= MAX;
              sat     <= 1'b1;
            end else begin
              bin_out <= bin_next;
              sat     <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_score.sv
// Bench for bcd_to_score: default instance plus a MAX_VAL=99 instance against a decimal model.
module tb_bcd_to_score;

  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] bcd_in;
  logic       out_ready;

  logic       in_ready, out_valid, sat, err;
  logic [6:0] bin_out;
  logic       in_ready99, out_valid99, sat99, err99;
  logic [6:0] bin_out99;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_to_score dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .sat(sat), .err(err)
  );

  bcd_to_score #(.MAX_VAL(99)) dut99 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready99), .bcd_in(bcd_in),
    .out_valid(out_valid99), .out_ready(out_ready), .bin_out(bin_out99), .sat(sat99), .err(err99)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: decimal arithmetic plus a latency countdown.
  logic       started = 1'b0;
  bit         m_ready, m_valid, m_busy, m_unspec;
  int         m_left;
  logic [7:0] m_in;
  int         m_bin, m_sat, m_err, m_bin99, m_sat99;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_ready = 1; m_valid = 0; m_busy = 0; m_left = 0; m_unspec = 0;
      m_bin = 0; m_sat = 0; m_err = 0; m_bin99 = 0; m_sat99 = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        int v;
        bit bad;
        m_busy  = 0;
        m_valid = 1;
        bad = (m_in[7:4] > 9) || (m_in[3:0] > 9);
        v   = int'(m_in[7:4]) * 10 + int'(m_in[3:0]);
        m_unspec = 0;
        m_err    = 0;
        if (bad) begin
`ifdef BCD_TO_SCORE_CHECK_EN
          m_err = 1; m_bin = 0; m_sat = 0; m_bin99 = 0; m_sat99 = 0;
`else
          m_unspec = 1;
`endif
        end else begin
          m_bin   = (v > 31) ? 31 : v;
          m_sat   = (v > 31) ? 1 : 0;
          m_bin99 = (v > 99) ? 99 : v;
          m_sat99 = (v > 99) ? 1 : 0;
        end
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 0;
        m_ready = 1;
      end
    end else if (m_ready && in_valid) begin
      m_ready = 0;
      m_busy  = 1;
      m_left  = LAT;
      m_in    = bcd_in;
    end
  end

  always @(posedge clk) begin
    #2;
    if (started) begin
      chk("cmp_out_valid", out_valid, m_valid);
      chk("cmp_in_ready", in_ready, m_ready);
      chk("cmp_out_valid99", out_valid99, m_valid);
      chk("cmp_in_ready99", in_ready99, m_ready);
      if (m_valid) begin
        chk("cmp_err", err, m_err);
        chk("cmp_err99", err99, m_err);
        if (!m_unspec) begin
          chk("cmp_bin", bin_out, m_bin);
          chk("cmp_sat", sat, m_sat);
          chk("cmp_bin99", bin_out99, m_bin99);
          chk("cmp_sat99", sat99, m_sat99);
        end
      end
`ifndef BCD_TO_SCORE_CHECK_EN
      chk("cmp_err_tied", err, 0);
`endif
    end
  end

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    bcd_in   = v;
    @(posedge clk); #2;
    in_valid = 1'b0;
    bcd_in   = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_bin_out"}, bin_out, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; bcd_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #2;

    // Basic conversion, out_ready already high
    out_ready = 1'b1;
    send(8'h27);
    wait_valid(lat);
    chk("latency_27", lat, 7);
    chk("bin_27", bin_out, 27);
    chk("sat_27", sat, 0);
    chk("err_27", err, 0);
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk("accepted_27_valid", out_valid, 0);
    chk("accepted_27_ready", in_ready, 1);

    // Saturation on both instances
    out_ready = 1'b1;
    send(8'h99);
    wait_valid(lat);
    chk("bin_99_max31", bin_out, 31);
    chk("sat_99_max31", sat, 1);
    chk("bin_99_max99", bin_out99, 99);
    chk("sat_99_max99", sat99, 0);
    @(posedge clk); #2;
    out_ready = 1'b0;

    // Backpressure
    send(8'h05);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_bin", bin_out, 5);
      chk("bp_in_ready", in_ready, 0);
    end
    handshake();
    chk("bp_after_in_ready", in_ready, 1);
    chk("bp_after_out_valid", out_valid, 0);

    // Input ignored while busy
    send(8'h21);
    @(posedge clk); #2;
    in_valid = 1'b1; bcd_in = 8'h12;
    @(posedge clk); #2;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("busy_bin", bin_out, 21);
    handshake();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      chk("busy_no_second", out_valid, 0);
    end

    // Reset mid-conversion
    send(8'h30);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    chk_reset_values("midrst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("midrst_no_valid", out_valid, 0);
    end
    send(8'h08);
    wait_valid(lat);
    chk("fresh_bin_08", bin_out, 8);
    handshake();

    // Invalid digit
    out_ready = 1'b1;
    send(8'h3A);
    wait_valid(lat);
    chk("latency_3a", lat, 7);
`ifdef BCD_TO_SCORE_CHECK_EN
    chk("err_3a", err, 1);
    chk("bin_3a", bin_out, 0);
    chk("sat_3a", sat, 0);
`else
    chk("err_3a_off", err, 0);
`endif
    @(posedge clk); #2;
    out_ready = 1'b0;

    // Randomized conversions; the compare process checks every cycle
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #2;
      end
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      out_ready = 1'($urandom_range(0, 1));
      send(v);
      wait_valid(lat);
      if (!out_ready) begin
        repeat ($urandom_range(0, 4)) begin
          @(posedge clk); #2;
        end
        handshake();
      end else begin
        @(posedge clk); #2;
        out_ready = 1'b0;
      end
    end

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
